// File: rtl/riscv_pkg.sv
// Shared RV32 core types: ALU op encoding, register file geometry and the
// divider state encoding.
package riscv_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_LUI    = 5'd10,
    ALU_MUL    = 5'd11,
    ALU_MULH   = 5'd12,
    ALU_MULHSU = 5'd13,
    ALU_MULHU  = 5'd14,
    ALU_DIV    = 5'd15,
    ALU_DIVU   = 5'd16,
    ALU_REM    = 5'd17,
    ALU_REMU   = 5'd18
  } alu_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract, and shift the resulting quotient bit into the dividend's LSB.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_dvd,
  input  logic [XLEN-1:0] i_dvs,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_dvd,
  output logic            o_qbit
);

  logic [XLEN:0] w_shift;
  logic          w_ge;

  // Partial remainder is one bit wider so the compare cannot wrap.
  always_comb begin
    w_shift = {i_rem, i_dvd[XLEN-1]};
    w_ge    = (w_shift >= {1'b0, i_dvs});
    o_qbit  = w_ge;
    o_rem   = w_ge ? XLEN'(w_shift - {1'b0, i_dvs}) : w_shift[XLEN-1:0];
    o_dvd   = {i_dvd[XLEN-2:0], w_ge};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU; one quotient bit per
// cycle, special cases resolved at accept.
module div_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  alu_op_e                   op_i,
  input  logic [XLEN-1:0]           dividend_i,
  input  logic [XLEN-1:0]           divisor_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                      flush_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [XLEN-1:0]           result_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e                r_state;
  alu_op_e                   r_op;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic                      r_q_neg;
  logic                      r_r_neg;
  logic [XLEN-1:0]           r_rem;
  logic [XLEN-1:0]           r_dvd;
  logic [XLEN-1:0]           r_dvs;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_busy;
  logic                      r_done;
  logic [XLEN-1:0]           r_result;
  logic [REG_ADDR_WIDTH-1:0] r_rd_out;

  logic            w_is_div;
  logic            w_in_signed;
  logic            w_in_rem;
  logic            w_accept;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic [XLEN-1:0] w_rem_nxt;
  logic [XLEN-1:0] w_dvd_nxt;
  logic            w_qbit;
  logic            w_r_signed;
  logic            w_r_rem;
  logic [XLEN-1:0] w_sel;
  logic            w_neg;
  logic [XLEN-1:0] w_final;

  div_step #(.XLEN(XLEN)) u_step (
    .i_rem  (r_rem),
    .i_dvd  (r_dvd),
    .i_dvs  (r_dvs),
    .o_rem  (w_rem_nxt),
    .o_dvd  (w_dvd_nxt),
    .o_qbit (w_qbit)
  );

  // Request decode, operand magnitudes and the accept-time special results.
  always_comb begin
    w_is_div    = op_i inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    w_in_signed = op_i inside {ALU_DIV, ALU_REM};
    w_in_rem    = op_i inside {ALU_REM, ALU_REMU};
    w_accept    = start_i && !flush_i && (r_state != DIV_CALC) && w_is_div;
    w_div_zero  = (divisor_i == '0);
    w_ovf       = w_in_signed && (dividend_i == INT_MIN) && (divisor_i == '1);
    w_special   = w_div_zero || w_ovf;
    w_abs_a     = (w_in_signed && dividend_i[XLEN-1]) ? (~dividend_i + XLEN'(1)) : dividend_i;
    w_abs_b     = (w_in_signed && divisor_i[XLEN-1])  ? (~divisor_i + XLEN'(1))  : divisor_i;
    if (w_div_zero) begin
      w_special_res = w_in_rem ? dividend_i : '1;
    end else begin
      w_special_res = w_in_rem ? '0 : INT_MIN;
    end
  end

  // Final result selection and sign fix-up, valid in the last CALC cycle.
  always_comb begin
    w_r_signed = r_op inside {ALU_DIV, ALU_REM};
    w_r_rem    = r_op inside {ALU_REM, ALU_REMU};
    w_sel      = w_r_rem ? w_rem_nxt : w_dvd_nxt;
    w_neg      = w_r_signed && (w_r_rem ? r_r_neg : r_q_neg);
    w_final    = w_neg ? (~w_sel + XLEN'(1)) : w_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= DIV_IDLE;
      r_op     <= ALU_ADD;
      r_rd     <= '0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_rd_out <= '0;
    end else if (flush_i) begin
      r_state <= DIV_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE, DIV_DONE: begin
          r_done  <= 1'b0;
          r_state <= DIV_IDLE;
          if (w_accept) begin
            r_op    <= op_i;
            r_rd    <= rd_addr_i;
            r_q_neg <= w_in_signed && (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
            r_r_neg <= w_in_signed && dividend_i[XLEN-1];
            r_rem   <= '0;
            r_dvd   <= w_abs_a;
            r_dvs   <= w_abs_b;
            r_cnt   <= CNT_W'(XLEN - 1);
            if (w_special) begin
              r_state  <= DIV_DONE;
              r_done   <= 1'b1;
              r_result <= w_special_res;
              r_rd_out <= rd_addr_i;
            end else begin
              r_state <= DIV_CALC;
              r_busy  <= 1'b1;
            end
          end
        end
        DIV_CALC: begin
          r_rem <= w_rem_nxt;
          r_dvd <= w_dvd_nxt;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) begin
            r_state  <= DIV_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= w_final;
            r_rd_out <= r_rd;
          end
        end
        default: begin
          r_state <= DIV_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign result_o  = r_result;
  assign rd_addr_o = r_rd_out;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signed/unsigned results,
// special cases, flush, back-to-back issue and asynchronous reset.
module tb_div_unit;
  import riscv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  alu_op_e     op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  int n_checks = 0;
  int n_fail   = 0;

  div_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .rd_addr_i  (rd_addr_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .rd_addr_o  (rd_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves the bench in cycle E+1 (start sampled at E).
  task automatic launch(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    op_i       = op;
    dividend_i = a;
    divisor_i  = b;
    rd_addr_i  = rd;
    start_i    = 1'b1;
    @(negedge clk);
    start_i    = 1'b0;
  endtask

  // Counts cycles (1 = E+1) until done_o, bounded; lat=41 means timeout.
  task automatic wait_done(output int lat, output int nbusy);
    lat   = 1;
    nbusy = 0;
    while (lat <= 40 && !done_o) begin
      if (busy_o) nbusy++;
      @(negedge clk);
      lat++;
    end
  endtask

  // Issue one op from idle and check latency, busy window, result and tag.
  task automatic do_op(input string tag, input alu_op_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input int exp_lat);
    int lat;
    int nbusy;
    @(negedge clk);
    launch(op, a, b, rd);
    wait_done(lat, nbusy);
    check_eq({tag, "_lat"},  32'(lat),   32'(exp_lat));
    check_eq({tag, "_busy"}, 32'(nbusy), 32'(exp_lat - 1));
    check_eq({tag, "_res"},  result_o,   exp);
    check_eq({tag, "_rd"},   32'(rd_addr_o), 32'(rd));
    check_eq({tag, "_dbusy"}, 32'(busy_o), 32'd0);
  endtask

  // Watch n cycles and return how many had done_o or busy_o set.
  task automatic quiet_cycles(input int n, output int ndone, output int nbusy);
    ndone = 0;
    nbusy = 0;
    for (int i = 0; i < n; i++) begin
      if (done_o) ndone++;
      if (busy_o) nbusy++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    int nbusy;
    int ndone;
    rst_n      = 1'b0;
    start_i    = 1'b0;
    flush_i    = 1'b0;
    op_i       = ALU_ADD;
    dividend_i = '0;
    divisor_i  = '0;
    rd_addr_i  = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_done", 32'(done_o), 32'd0);
    check_eq("rst_res",  result_o, 32'd0);
    check_eq("rst_rd",   32'(rd_addr_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("divu_100_7",  ALU_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 33);
    do_op("remu_100_7",  ALU_REMU, 32'd100, 32'd7, 5'd5, 32'd2,  33);
    do_op("div_m7_2",    ALU_DIV,  32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 33);
    do_op("rem_m7_2",    ALU_REM,  32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 33);
    do_op("div_7_m2",    ALU_DIV,  32'd7, 32'hFFFF_FFFE, 5'd8, 32'hFFFF_FFFD, 33);
    do_op("rem_7_m2",    ALU_REM,  32'd7, 32'hFFFF_FFFE, 5'd9, 32'd1, 33);
    do_op("divu_min_3",  ALU_DIVU, 32'h8000_0000, 32'd3, 5'd10, 32'h2AAA_AAAA, 33);
    do_op("divu_5_0",    ALU_DIVU, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF, 1);
    do_op("rem_5_0",     ALU_REM,  32'd5, 32'd0, 5'd12, 32'd5, 1);
    do_op("div_m1_0",    ALU_DIV,  32'hFFFF_FFFF, 32'd0, 5'd13, 32'hFFFF_FFFF, 1);
    do_op("div_ovf",     ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1);
    do_op("rem_ovf",     ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 1);

    // Flush in CALC cycle 10 kills the op with no done pulse.
    @(negedge clk);
    launch(ALU_DIVU, 32'd100, 32'd7, 5'd1);
    repeat (9) @(negedge clk);
    check_eq("flush_pre_busy", 32'(busy_o), 32'd1);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check_eq("flush_busy", 32'(busy_o), 32'd0);
    check_eq("flush_done", 32'(done_o), 32'd0);
    quiet_cycles(40, ndone, nbusy);
    check_eq("flush_no_done", 32'(ndone), 32'd0);
    check_eq("flush_res_hold", result_o, 32'd0);
    do_op("divu_9_3", ALU_DIVU, 32'd9, 32'd3, 5'd2, 32'd3, 33);

    // Flush together with start drops the request.
    @(negedge clk);
    flush_i = 1'b1;
    launch(ALU_DIVU, 32'd50, 32'd5, 5'd4);
    flush_i = 1'b0;
    quiet_cycles(40, ndone, nbusy);
    check_eq("flstart_done", 32'(ndone), 32'd0);
    check_eq("flstart_busy", 32'(nbusy), 32'd0);

    // Non-divide op is ignored.
    @(negedge clk);
    launch(ALU_ADD, 32'd50, 32'd5, 5'd4);
    quiet_cycles(40, ndone, nbusy);
    check_eq("add_done", 32'(ndone), 32'd0);
    check_eq("add_busy", 32'(nbusy), 32'd0);
    check_eq("add_res_hold", result_o, 32'd3);

    // Start in the DONE cycle: second result exactly 33 cycles later.
    do_op("b2b_first", ALU_DIVU, 32'd100, 32'd7, 5'd20, 32'd14, 33);
    launch(ALU_REMU, 32'd100, 32'd7, 5'd21);
    wait_done(lat, nbusy);
    check_eq("b2b_lat",  32'(lat),   32'd33);
    check_eq("b2b_busy", 32'(nbusy), 32'd32);
    check_eq("b2b_res",  result_o,   32'd2);
    check_eq("b2b_rd",   32'(rd_addr_o), 32'd21);
    @(negedge clk);
    check_eq("b2b_done_drop", 32'(done_o), 32'd0);

    // Reset mid-CALC clears outputs asynchronously.
    launch(ALU_DIVU, 32'd1000, 32'd3, 5'd17);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy_o), 32'd0);
    check_eq("arst_done", 32'(done_o), 32'd0);
    check_eq("arst_res",  result_o, 32'd0);
    check_eq("arst_rd",   32'(rd_addr_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet_cycles(40, ndone, nbusy);
    check_eq("arst_no_done", 32'(ndone), 32'd0);
    do_op("divu_max_1", ALU_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd31, 32'hFFFF_FFFF, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 divider that executes the RV32M DIV, DIVU, REM and REMU operations issued by the EX stage. The pipeline is the initiator: it raises a one-cycle start with operands and an operation code. This block answers with a busy window, followed by a one-cycle done pulse carrying the result. `busy_o` is the source of the `hazard_t.division` stall term, and `done_o`/`result_o` are muxed into the EX/MEM `alu_result`.

## Interface
- `XLEN`, default 32 (`riscv_pkg::XLEN`): operand and result width.
- `clk`: input, 1 bit. Single clock; all state changes on its rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `start_i`: input, 1 bit. Request strobe, sampled on the rising edge.
- `op_i`: input, `alu_op_e` (5 bits). Accepted values: `ALU_DIV`, `ALU_DIVU`, `ALU_REM`, `ALU_REMU`.
- `dividend_i`: input, XLEN bits. rs1 value.
- `divisor_i`: input, XLEN bits. rs2 value.
- `rd_addr_i`: input, `REG_ADDR_WIDTH` bits. Destination tag, returned with the result.
- `flush_i`: input, 1 bit. Aborts any in-flight operation.
- `busy_o`: output, 1 bit. Operation in progress; drives `hazard_t.division`.
- `done_o`: output, 1 bit. One-cycle result-valid pulse.
- `result_o`: output, XLEN bits. Quotient or remainder.
- `rd_addr_o`: output, `REG_ADDR_WIDTH` bits. Tag captured at start.

## Operation
- States are `DIV_IDLE`, `DIV_CALC` and `DIV_DONE`.
- **Accept:**
  - A request is accepted on an edge where `start_i`=1, `flush_i`=0, state is IDLE or DONE, and `op_i` is one of the four div ops.
  - Any other `op_i` with `start_i` is ignored and the state is unchanged.
  - A `start_i` arriving while in CALC is ignored.
- **Capture:** latch `op_i` and `rd_addr_i`.
  - For signed ops, store |dividend| and |divisor|. Negation is two's complement, so |0x80000000| = 0x80000000, which is correct as unsigned.
  - Latch `q_neg` = sign(a) XOR sign(b) and `r_neg` = sign(a).
- **Special cases are resolved at accept.** Go straight to DONE and skip CALC:
  - Divisor is 0: the quotient is 0xFFFFFFFF for both signed and unsigned ops; the remainder is the dividend, unmodified.
  - Signed overflow (dividend 0x80000000, divisor 0xFFFFFFFF): the quotient is 0x80000000 and the remainder is 0.
- **CALC:** restoring division, one quotient bit per cycle, MSB first.
  - Each cycle: `rem = {rem[XLEN-2:0], dvd[XLEN-1]}`, then `dvd <<= 1`.
  - If `rem >= dvs`, then `rem -= dvs` and the quotient bit is 1.
  - The partial remainder is XLEN+1 bits wide so the compare never overflows.
  - A 5-bit counter loads XLEN-1; exit to DONE after the cycle in which it reads 0, i.e. after exactly XLEN iterations.
- **DONE entry:**
  - Select the quotient (DIV/DIVU) or the remainder (REM/REMU).
  - Negate it if the matching `q_neg`/`r_neg` flag is set for a signed op.
  - Register the value into `result_o`.
- **DONE:** `done_o`=1 for exactly one cycle, then return to IDLE unless a new start is accepted in that same cycle.
- `result_o` and `rd_addr_o` hold until the next DONE entry.
- **Flush:** `flush_i`=1 in any state sends the block to IDLE on the next edge, with `done_o`=0 and `busy_o`=0 from the next cycle. Flush wins over a simultaneous `start_i`.
- **Reset (asserted at any time, including mid-CALC):**
  - State goes to IDLE immediately.
  - `busy_o`=0, `done_o`=0, `result_o`=0, `rd_addr_o`=0.
  - Internal registers and counter are cleared to 0.

## Timing
- The start is sampled at edge E.
- Normal path:
  - `busy_o`=1 in cycles E+1 through E+XLEN.
  - `done_o`=1 in cycle E+XLEN+1 (33 cycles for XLEN=32).
- Special-case path: `busy_o` never asserts; `done_o`=1 in cycle E+1.
- `busy_o` is low in the DONE cycle, so the stalled EX stage advances and captures `result_o` on that edge.
- Back-to-back: a start accepted in the DONE cycle begins CALC on the next edge with no idle bubble.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Add `div_state_e` (`DIV_IDLE`, `DIV_CALC`, `DIV_DONE`; `logic [1:0]`) to `riscv_pkg`.
- Reuse `alu_op_e`, `XLEN` and `REG_ADDR_WIDTH` from `riscv_pkg`. No new parameters go in the package.
- A natural sub-module is the combinational `div_step`: one shift/compare/subtract iteration, (rem, dvd, dvs) → (rem', dvd', qbit).
- Sign handling and the FSM stay in `div_unit`.

## Test plan
- **DIVU:** DIVU 100 / 7 → `busy_o` high 32 cycles, then `done_o` at E+33 with `result_o`=14. REMU with the same operands → 2; `rd_addr_o` echoes the tag, e.g. 5.
- **Signed:** DIV -7 / 2 → 0xFFFFFFFD; REM -7 / 2 → 0xFFFFFFFF; DIV 7 / -2 → 0xFFFFFFFD; REM 7 / -2 → 1.
- **Divide by zero:** DIVU 5 / 0 → 0xFFFFFFFF at E+1, `busy_o` never high; REM 5 / 0 → 5; DIV -1 / 0 → 0xFFFFFFFF.
- **Signed overflow:** DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at E+1; REM → 0.
- **Flush:** assert `flush_i` in CALC cycle 10 → `busy_o`=0 next cycle, no `done_o`. A subsequent DIVU 9 / 3 → 3 with correct latency. A flush in the same cycle as a start → request dropped.
- **Back-to-back and reset:**
  - A start in the DONE cycle → second result arrives exactly 33 cycles later.
  - Assert `rst_n`=0 mid-CALC → all outputs 0 asynchronously. After release, DIVU 0xFFFFFFFF / 1 → 0xFFFFFFFF.
  - A non-div `op_i` (`ALU_ADD`) with `start_i` → no response.
